// File: rtl/mips_store_buffer.sv
// mips_store_buffer
// Data-memory stage behind the MIPS core. Stores are posted into a small FIFO
// and drained to a handshaked memory port one transaction at a time. Loads
// run as single outstanding reads and stall the core until their data is back.
//
// Build option: define STORE_FORWARD_EN to enable store-to-load forwarding.
// With it, a load that hits a queued store gets the youngest matching data
// combinationally. A load that misses is allowed to bypass the queued stores.
// Without it, a load waits until the FIFO has fully drained.
//
// state | meaning
// IDLE  | nothing outstanding on the memory port; pick the next transaction
// WR    | FIFO head is being written; wait for mem_ack, then pop
// RD    | core load is being read; wait for mem_ack, then capture data

module mips_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] direccion,
    input  logic [DW-1:0] palabra,
    output logic [DW-1:0] leer_dato,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t state, state_next;

    // FIFO keeps only the word address; byte-offset bits are never used.
    logic [AW-3:0] fifo_waddr [DEPTH];
    logic [DW-1:0] fifo_data  [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic [DW-1:0] load_reg;
    logic          load_done;

    logic          ack;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          load_req;
    logic          load_go;
    logic          load_capture;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    logic          req_next;
    logic          we_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] wdata_next;

    logic          unused_low;

    assign unused_low = ^direccion[1:0];

    // An ack with no request outstanding (e.g. straggling in after a reset)
    // must not advance anything.
    assign ack       = mem_ack & mem_req;
    assign fifo_full = (count == CW'(DEPTH));

    // Store has priority when both strobes are high; the read is dropped.
    assign push      = cpu_we & ~fifo_full;

    // load_done marks the single cycle in which the captured data is being
    // returned; the same load must not be re-issued in that cycle.
    assign load_req  = cpu_re & ~cpu_we & ~load_done;

`ifdef STORE_FORWARD_EN
    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cpu_re && !cpu_we && (i < int'(count)) &&
                (fifo_waddr[rd_ptr + PW'(i)] == direccion[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[rd_ptr + PW'(i)];
            end
        end
    end

    assign load_go = load_req & ~fwd_hit;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign load_go  = load_req & (count == '0);
`endif

    assign cpu_stall = (cpu_we & fifo_full) | (load_req & ~fwd_hit);
    assign leer_dato = fwd_hit ? fwd_data : load_reg;

    // FIFO storage; pointers and count live in the reset domain below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_waddr[wr_ptr] <= direccion[AW-1:2];
            fifo_data[wr_ptr]  <= palabra;
        end
    end

    // FIFO pointers and occupancy; a pop frees a slot only for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state and next memory-port values; port outputs are registered.
    always_comb begin
        state_next   = state;
        req_next     = mem_req;
        we_next      = mem_we;
        addr_next    = mem_addr;
        wdata_next   = mem_wdata;
        pop          = 1'b0;
        load_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_go) begin
                    state_next = S_RD;
                    req_next   = 1'b1;
                    we_next    = 1'b0;
                    addr_next  = {direccion[AW-1:2], 2'b00};
                end else if (count != '0) begin
                    state_next = S_WR;
                    req_next   = 1'b1;
                    we_next    = 1'b1;
                    addr_next  = {fifo_waddr[rd_ptr], 2'b00};
                    wdata_next = fifo_data[rd_ptr];
                end
            end
            S_WR: begin
                if (ack) begin
                    state_next = S_IDLE;
                    req_next   = 1'b0;
                    pop        = 1'b1;
                end
            end
            S_RD: begin
                if (ack) begin
                    state_next   = S_IDLE;
                    req_next     = 1'b0;
                    load_capture = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    // State register and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
        end
    end

    // Load data capture and the one-cycle data-return flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_reg  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= load_capture;
            if (load_capture) begin
                load_reg <= mem_rdata;
            end
        end
    end

endmodule
